// File: rtl/nb_cmp_pkg.sv
// Shared definitions for the sequential magnitude comparator: FSM encoding and
// the bit-counter width helper.
package nb_cmp_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CMP  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Counter must hold n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/nb_twos_comp.sv
// n-bit two's-complement sign changer: y = ~x + 1, wrapping at n bits.
module nb_twos_comp #(
  parameter int unsigned n = 5
) (
  input  logic [n-1:0] x,
  output logic [n-1:0] y
);

  assign y = ~x + n'(1);

endmodule

// File: rtl/nb_mag_compare_seq.sv
// Sequential MSB-first magnitude comparator; optional |a| vs |b| in signed mode,
// fixed n compare cycles, one-cycle done pulse with registered result flags.
module nb_mag_compare_seq
  import nb_cmp_pkg::*;
#(
  parameter int unsigned n = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         signed_mode,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic         busy,
  output logic         done,
  output logic         a_gt_b,
  output logic         a_eq_b,
  output logic         a_lt_b
);

  localparam int unsigned CNT_W = cnt_width(n);

  logic [n-1:0]     neg_a, neg_b, mag_a, mag_b;
  logic [1:0]       state, state_n;
  logic [n-1:0]     sh_a, sh_a_n, sh_b, sh_b_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             gt, gt_n, lt, lt_n;
  logic             busy_n, done_n, a_gt_b_n, a_eq_b_n, a_lt_b_n;

  nb_twos_comp #(.n(n)) u_neg_a (.x(a), .y(neg_a));
  nb_twos_comp #(.n(n)) u_neg_b (.x(b), .y(neg_b));

  // The most negative value negates to itself, read unsigned as 2^(n-1).
  assign mag_a = (signed_mode & a[n-1]) ? neg_a : a;
  assign mag_b = (signed_mode & b[n-1]) ? neg_b : b;

  always_comb begin
    state_n  = state;
    sh_a_n   = sh_a;
    sh_b_n   = sh_b;
    cnt_n    = cnt;
    gt_n     = gt;
    lt_n     = lt;
    busy_n   = busy;
    done_n   = 1'b0;
    a_gt_b_n = a_gt_b;
    a_eq_b_n = a_eq_b;
    a_lt_b_n = a_lt_b;
    case (state)
      S_IDLE: begin
        if (start) begin
          sh_a_n  = mag_a;
          sh_b_n  = mag_b;
          gt_n    = 1'b0;
          lt_n    = 1'b0;
          cnt_n   = CNT_W'(n - 1);
          busy_n  = 1'b1;
          state_n = S_CMP;
        end
      end
      S_CMP: begin
        // First differing bit from the MSB decides; later bits are ignored.
        if (!gt && !lt && (sh_a[n-1] != sh_b[n-1])) begin
          gt_n = sh_a[n-1];
          lt_n = sh_b[n-1];
        end
        sh_a_n = {sh_a[n-2:0], 1'b0};
        sh_b_n = {sh_b[n-2:0], 1'b0};
        cnt_n  = cnt - CNT_W'(1);
        if (cnt == '0) begin
          state_n = S_DONE;
        end
      end
      S_DONE: begin
        done_n   = 1'b1;
        busy_n   = 1'b0;
        a_gt_b_n = gt;
        a_lt_b_n = lt;
        a_eq_b_n = ~gt & ~lt;
        state_n  = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      sh_a   <= '0;
      sh_b   <= '0;
      cnt    <= '0;
      gt     <= 1'b0;
      lt     <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      a_gt_b <= 1'b0;
      a_eq_b <= 1'b0;
      a_lt_b <= 1'b0;
    end else begin
      state  <= state_n;
      sh_a   <= sh_a_n;
      sh_b   <= sh_b_n;
      cnt    <= cnt_n;
      gt     <= gt_n;
      lt     <= lt_n;
      busy   <= busy_n;
      done   <= done_n;
      a_gt_b <= a_gt_b_n;
      a_eq_b <= a_eq_b_n;
      a_lt_b <= a_lt_b_n;
    end
  end

endmodule
